// File: rtl/dsm_pkg.sv
// Shared constants and types for the sigma-delta modulator feeder.
package dsm_pkg;

    localparam int DSM_W       = 24;
    localparam int INTERP_LOG2 = 3;

    // dem_count value on which every output update takes effect
    localparam logic [1:0] STEP_PHASE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL
    } state_t;

    typedef logic signed [DSM_W-1:0] sample_t;

endpackage

// File: rtl/dsm_stereo_fifo.sv
// Stereo-pair FIFO with a registered head word (first-word fall-through).
module dsm_stereo_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             mclk512,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [PTR_W:0]   count;
    logic             wr_en;
    logic             rd_en;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign wr_en    = push && !full;
    assign rd_en    = pop && !empty;
    assign rd_ptr_n = rd_en ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_ff @(posedge mclk512) begin
        if (wr_en && !clr)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge mclk512 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_n;
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // The head follows the next read slot; a write landing in that slot bypasses the array.
    always_ff @(posedge mclk512 or posedge reset) begin
        if (reset)
            head <= '0;
        else if (clr)
            head <= '0;
        else if (wr_en && (wr_ptr == rd_ptr_n))
            head <= wdata;
        else
            head <= mem[rd_ptr_n];
    end

endmodule

// File: rtl/dsm_lin_interp.sv
// Linear interpolator feeding the stereo sigma-delta modulator, one step per 4 mclk512 cycles.
// Optional zero-order-hold mode (zoh_sel port) is enabled with `define DSM_INTERP_ZOH_EN.
module dsm_lin_interp #(
    parameter int DSM_W       = dsm_pkg::DSM_W,
    parameter int INTERP_LOG2 = dsm_pkg::INTERP_LOG2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             mclk512,
    input  logic             reset,
    input  logic             dsm_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DSM_W-1:0] in_left,
    input  logic [DSM_W-1:0] in_right,
`ifdef DSM_INTERP_ZOH_EN
    input  logic             zoh_sel,
`endif
    output logic [DSM_W-1:0] dsm_chan1,
    output logic [DSM_W-1:0] dsm_chan2,
    output logic [1:0]       dem_count,
    output logic             underrun
);

    import dsm_pkg::*;

    localparam int ACC_W = DSM_W + INTERP_LOG2 + 1;
    localparam int DLT_W = DSM_W + 1;
    localparam logic [INTERP_LOG2-1:0] K_LAST = '1;

    state_t                   state;
    state_t                   state_n;
    logic                     step;
    logic                     push;
    logic                     load;
    logic                     advance;
    logic                     set_underrun;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     zoh;
    logic [2*DSM_W-1:0]       fifo_head;
    logic [DSM_W-1:0]         tgt_l;
    logic [DSM_W-1:0]         tgt_r;
    logic signed [ACC_W-1:0]  acc_l;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  acc_l_ld;
    logic signed [ACC_W-1:0]  acc_r_ld;
    logic signed [DLT_W-1:0]  dlt_l;
    logic signed [DLT_W-1:0]  dlt_r;
    logic signed [DLT_W-1:0]  dlt_l_ld;
    logic signed [DLT_W-1:0]  dlt_r_ld;
    logic [INTERP_LOG2-1:0]   k;

    function automatic logic signed [ACC_W-1:0] scale_up(input logic [DSM_W-1:0] v);
        return {v[DSM_W-1], v, {INTERP_LOG2{1'b0}}};
    endfunction

    function automatic logic signed [ACC_W-1:0] widen(input logic signed [DLT_W-1:0] d);
        return {{INTERP_LOG2{d[DLT_W-1]}}, d};
    endfunction

    assign step      = (dem_count == STEP_PHASE);
    assign in_ready  = !fifo_full;
    assign push      = in_valid && in_ready;
    assign tgt_l     = fifo_head[2*DSM_W-1:DSM_W];
    assign tgt_r     = fifo_head[DSM_W-1:0];
    assign dsm_chan1 = acc_l[INTERP_LOG2 +: DSM_W];
    assign dsm_chan2 = acc_r[INTERP_LOG2 +: DSM_W];

`ifdef DSM_INTERP_ZOH_EN
    assign zoh = zoh_sel;
`else
    assign zoh = 1'b0;
`endif

    dsm_stereo_fifo #(
        .WIDTH (2*DSM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .mclk512 (mclk512),
        .reset   (reset),
        .clr     (dsm_clr),
        .push    (push),
        .wdata   ({in_left, in_right}),
        .pop     (load),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    // Segment start folds the first increment in, so the load step already moves the output.
    always_comb begin
        dlt_l_ld = {tgt_l[DSM_W-1], tgt_l} - {dsm_chan1[DSM_W-1], dsm_chan1};
        dlt_r_ld = {tgt_r[DSM_W-1], tgt_r} - {dsm_chan2[DSM_W-1], dsm_chan2};
        acc_l_ld = scale_up(dsm_chan1) + widen(dlt_l_ld);
        acc_r_ld = scale_up(dsm_chan2) + widen(dlt_r_ld);
        if (zoh) begin
            dlt_l_ld = '0;
            dlt_r_ld = '0;
            acc_l_ld = scale_up(tgt_l);
            acc_r_ld = scale_up(tgt_r);
        end
    end

    always_comb begin
        state_n      = state;
        load         = 1'b0;
        advance      = 1'b0;
        set_underrun = 1'b0;
        if (step) begin
            case (state)
                IDLE, STALL: begin
                    if (!fifo_empty) begin
                        load    = 1'b1;
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (k != K_LAST) begin
                        advance = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_n      = STALL;
                        set_underrun = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk512 or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (dsm_clr)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge mclk512 or posedge reset) begin
        if (reset) begin
            dem_count <= 2'd0;
            underrun  <= 1'b0;
        end else if (dsm_clr) begin
            dem_count <= 2'd0;
            underrun  <= 1'b0;
        end else begin
            dem_count <= dem_count + 2'd1;
            if (set_underrun)
                underrun <= 1'b1;
        end
    end

    always_ff @(posedge mclk512 or posedge reset) begin
        if (reset) begin
            acc_l <= '0;
            acc_r <= '0;
            dlt_l <= '0;
            dlt_r <= '0;
            k     <= '0;
        end else if (dsm_clr) begin
            acc_l <= '0;
            acc_r <= '0;
            dlt_l <= '0;
            dlt_r <= '0;
            k     <= '0;
        end else if (load) begin
            acc_l <= acc_l_ld;
            acc_r <= acc_r_ld;
            dlt_l <= dlt_l_ld;
            dlt_r <= dlt_r_ld;
            k     <= '0;
        end else if (advance) begin
            acc_l <= acc_l + widen(dlt_l);
            acc_r <= acc_r + widen(dlt_r);
            k     <= k + INTERP_LOG2'(1);
        end
    end

endmodule

// File: tb/tb_dsm_lin_interp.sv
// Directed self-checking bench for dsm_lin_interp (default build, linear interpolation only).
module tb_dsm_lin_interp;

    logic        mclk512;
    logic        reset;
    logic        dsm_clr;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_left;
    logic [23:0] in_right;
    logic [23:0] dsm_chan1;
    logic [23:0] dsm_chan2;
    logic [1:0]  dem_count;
    logic        underrun;

    int checks = 0;
    int passed = 0;

    logic [23:0] fill_l [4] = '{24'h001000, 24'h001800, 24'h002000, 24'h002800};
    logic [23:0] fill_r [4] = '{24'h000800, 24'h000000, 24'h000000, 24'h000000};

    dsm_lin_interp dut (
        .mclk512   (mclk512),
        .reset     (reset),
        .dsm_clr   (dsm_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_left   (in_left),
        .in_right  (in_right),
        .dsm_chan1 (dsm_chan1),
        .dsm_chan2 (dsm_chan2),
        .dem_count (dem_count),
        .underrun  (underrun)
    );

    initial begin
        mclk512 = 1'b0;
        forever #5 mclk512 = ~mclk512;
    end

    // Advance to the first falling edge that follows a step edge.
    task automatic next_step();
        for (int n = 0; n < 8; n++) begin
            @(negedge mclk512);
            if (dem_count == 2'd0) break;
        end
        if (dem_count != 2'd0) begin
            checks++;
            $display("[TB] FAIL step_timeout: dem_count got %0d, expected 0", dem_count);
        end
    endtask

    task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        for (int i = 0; i < 64; i++) begin
            accepted = in_ready;
            @(negedge mclk512);
            if (accepted) break;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            $display("[TB] FAIL push_timeout: in_ready got 0, expected 1 within 64 cycles");
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        dsm_clr  = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        repeat (3) @(negedge mclk512);
        if (dsm_chan1 !== 24'h0) $display("[TB] FAIL reset_chan1: got %h, expected 000000", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h0) $display("[TB] FAIL reset_chan2: got %h, expected 000000", dsm_chan2); else passed++;
        checks++;
        if (dem_count !== 2'd0) $display("[TB] FAIL reset_dem_count: got %0d, expected 0", dem_count); else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready); else passed++;
        checks++;
        if (underrun !== 1'b0) $display("[TB] FAIL reset_underrun: got %b, expected 0", underrun); else passed++;
        checks++;
        reset = 1'b0;
        @(negedge mclk512);
        if (dem_count !== 2'd1) $display("[TB] FAIL dem_count_run: got %0d, expected 1", dem_count); else passed++;
        checks++;
    endtask

    task automatic test_linear_ramp();
        logic [23:0] exp;
        push_pair(24'h000800, 24'h000000);
        for (int i = 1; i <= 8; i++) begin
            next_step();
            exp = 24'(i * 24'h100);
            if (dsm_chan1 !== exp) $display("[TB] FAIL ramp_up_chan1 step %0d: got %h, expected %h", i, dsm_chan1, exp); else passed++;
            checks++;
            if (dsm_chan2 !== 24'h0) $display("[TB] FAIL ramp_up_chan2 step %0d: got %h, expected 000000", i, dsm_chan2); else passed++;
            checks++;
        end
    endtask

    task automatic test_negative_ramp();
        logic [23:0] exp;
        push_pair(24'hFFF800, 24'h000000);
        for (int i = 1; i <= 8; i++) begin
            next_step();
            exp = 24'h000800 - 24'(i * 24'h200);
            if (dsm_chan1 !== exp) $display("[TB] FAIL ramp_down_chan1 step %0d: got %h, expected %h", i, dsm_chan1, exp); else passed++;
            checks++;
        end
        if (underrun !== 1'b0) $display("[TB] FAIL seamless_underrun: got %b, expected 0", underrun); else passed++;
        checks++;
    endtask

    task automatic test_full_scale();
        logic [23:0] prev_l;
        logic [23:0] prev_r;
        push_pair(24'h7FFFFF, 24'h800000);
        push_pair(24'h800000, 24'h7FFFFF);
        next_step();
        if (dsm_chan1 !== 24'h0FF8FF) $display("[TB] FAIL fs_up_first_chan1: got %h, expected 0ff8ff", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'hF00000) $display("[TB] FAIL fs_up_first_chan2: got %h, expected f00000", dsm_chan2); else passed++;
        checks++;
        repeat (7) next_step();
        if (dsm_chan1 !== 24'h7FFFFF) $display("[TB] FAIL fs_up_final_chan1: got %h, expected 7fffff", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h800000) $display("[TB] FAIL fs_up_final_chan2: got %h, expected 800000", dsm_chan2); else passed++;
        checks++;
        next_step();
        if (dsm_chan1 !== 24'h5FFFFF) $display("[TB] FAIL fs_down_first_chan1: got %h, expected 5fffff", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h9FFFFF) $display("[TB] FAIL fs_down_first_chan2: got %h, expected 9fffff", dsm_chan2); else passed++;
        checks++;
        prev_l = dsm_chan1;
        prev_r = dsm_chan2;
        for (int i = 2; i <= 8; i++) begin
            next_step();
            if (!($signed(dsm_chan1) < $signed(prev_l)))
                $display("[TB] FAIL fs_monotonic_chan1 step %0d: got %h, expected below %h", i, dsm_chan1, prev_l);
            else
                passed++;
            checks++;
            if (!($signed(dsm_chan2) > $signed(prev_r)))
                $display("[TB] FAIL fs_monotonic_chan2 step %0d: got %h, expected above %h", i, dsm_chan2, prev_r);
            else
                passed++;
            checks++;
            prev_l = dsm_chan1;
            prev_r = dsm_chan2;
        end
        if (dsm_chan1 !== 24'h800000) $display("[TB] FAIL fs_down_final_chan1: got %h, expected 800000", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h7FFFFF) $display("[TB] FAIL fs_down_final_chan2: got %h, expected 7fffff", dsm_chan2); else passed++;
        checks++;
        if (underrun !== 1'b0) $display("[TB] FAIL fs_underrun: got %b, expected 0", underrun); else passed++;
        checks++;
    endtask

    task automatic test_underrun_resume();
        logic changed;
        next_step();
        if (underrun !== 1'b1) $display("[TB] FAIL stall_underrun: got %b, expected 1", underrun); else passed++;
        checks++;
        if (dsm_chan1 !== 24'h800000) $display("[TB] FAIL stall_hold_chan1: got %h, expected 800000", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h7FFFFF) $display("[TB] FAIL stall_hold_chan2: got %h, expected 7fffff", dsm_chan2); else passed++;
        checks++;
        next_step();
        if (dsm_chan1 !== 24'h800000) $display("[TB] FAIL stall_hold2_chan1: got %h, expected 800000", dsm_chan1); else passed++;
        checks++;
        push_pair(24'h800100, 24'h7FFFFF);
        changed = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge mclk512);
            if (dsm_chan1 !== 24'h800000) begin
                changed = 1'b1;
                break;
            end
        end
        if (changed !== 1'b1) $display("[TB] FAIL resume_latency: output changed %b, expected 1 within 4 cycles", changed); else passed++;
        checks++;
        if (dsm_chan1 !== 24'h800020) $display("[TB] FAIL resume_first_chan1: got %h, expected 800020", dsm_chan1); else passed++;
        checks++;
        if (underrun !== 1'b1) $display("[TB] FAIL resume_underrun_sticky: got %b, expected 1", underrun); else passed++;
        checks++;
        repeat (7) next_step();
        if (dsm_chan1 !== 24'h800100) $display("[TB] FAIL resume_final_chan1: got %h, expected 800100", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h7FFFFF) $display("[TB] FAIL resume_final_chan2: got %h, expected 7fffff", dsm_chan2); else passed++;
        checks++;
    endtask

    task automatic test_fifo_full();
        logic accepted;
        dsm_clr = 1'b1;
        @(negedge mclk512);
        dsm_clr = 1'b0;
        push_pair(24'h000800, 24'h000000);
        next_step();
        if (dsm_chan1 !== 24'h000100) $display("[TB] FAIL fill_seg_first: got %h, expected 000100", dsm_chan1); else passed++;
        checks++;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_left  = fill_l[i];
            in_right = fill_r[i];
            @(negedge mclk512);
        end
        if (in_ready !== 1'b0) $display("[TB] FAIL fill_in_ready_full: got %b, expected 0", in_ready); else passed++;
        checks++;
        in_left  = 24'h003000;
        in_right = 24'h000000;
        accepted = 1'b0;
        for (int n = 0; n < 48; n++) begin
            @(negedge mclk512);
            if (in_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (accepted !== 1'b1) $display("[TB] FAIL fill_ready_after_pop: got %b, expected 1", accepted); else passed++;
        checks++;
        if (dsm_chan1 !== 24'h000900) $display("[TB] FAIL fill_pop_load_chan1: got %h, expected 000900", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h000100) $display("[TB] FAIL fill_pop_load_chan2: got %h, expected 000100", dsm_chan2); else passed++;
        checks++;
        @(negedge mclk512);
        in_valid = 1'b0;
        if (in_ready !== 1'b0) $display("[TB] FAIL fill_fifth_accepted: got %b, expected 0", in_ready); else passed++;
        checks++;
    endtask

    task automatic test_clear_mid_segment();
        repeat (3) next_step();
        if (dsm_chan1 !== 24'h000C00) $display("[TB] FAIL k3_chan1: got %h, expected 000c00", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h000400) $display("[TB] FAIL k3_chan2: got %h, expected 000400", dsm_chan2); else passed++;
        checks++;
        dsm_clr = 1'b1;
        @(negedge mclk512);
        dsm_clr = 1'b0;
        if (dsm_chan1 !== 24'h0) $display("[TB] FAIL clr_chan1: got %h, expected 000000", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h0) $display("[TB] FAIL clr_chan2: got %h, expected 000000", dsm_chan2); else passed++;
        checks++;
        if (dem_count !== 2'd0) $display("[TB] FAIL clr_dem_count: got %0d, expected 0", dem_count); else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL clr_in_ready: got %b, expected 1", in_ready); else passed++;
        checks++;
        if (underrun !== 1'b0) $display("[TB] FAIL clr_underrun: got %b, expected 0", underrun); else passed++;
        checks++;
        next_step();
        if (dsm_chan1 !== 24'h0) $display("[TB] FAIL clr_flushed_chan1: got %h, expected 000000", dsm_chan1); else passed++;
        checks++;
        push_pair(24'h000800, 24'h000400);
        next_step();
        if (dsm_chan1 !== 24'h000100) $display("[TB] FAIL clr_ramp_chan1: got %h, expected 000100", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h000080) $display("[TB] FAIL clr_ramp_chan2: got %h, expected 000080", dsm_chan2); else passed++;
        checks++;
    endtask

    task automatic test_reset_mid_segment();
        in_valid = 1'b1;
        in_left  = 24'h000123;
        in_right = 24'h000321;
        repeat (4) @(negedge mclk512);
        in_valid = 1'b0;
        if (in_ready !== 1'b0) $display("[TB] FAIL pre_reset_in_ready: got %b, expected 0", in_ready); else passed++;
        checks++;
        next_step();
        if (dsm_chan1 !== 24'h000300) $display("[TB] FAIL pre_reset_chan1: got %h, expected 000300", dsm_chan1); else passed++;
        checks++;
        #3 reset = 1'b1;
        #1;
        if (dsm_chan1 !== 24'h0) $display("[TB] FAIL async_reset_chan1: got %h, expected 000000", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'h0) $display("[TB] FAIL async_reset_chan2: got %h, expected 000000", dsm_chan2); else passed++;
        checks++;
        if (dem_count !== 2'd0) $display("[TB] FAIL async_reset_dem_count: got %0d, expected 0", dem_count); else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL async_reset_in_ready: got %b, expected 1", in_ready); else passed++;
        checks++;
        @(negedge mclk512);
        reset = 1'b0;
        push_pair(24'h000080, 24'hFFFF80);
        next_step();
        if (dsm_chan1 !== 24'h000010) $display("[TB] FAIL post_reset_chan1: got %h, expected 000010", dsm_chan1); else passed++;
        checks++;
        if (dsm_chan2 !== 24'hFFFFF0) $display("[TB] FAIL post_reset_chan2: got %h, expected fffff0", dsm_chan2); else passed++;
        checks++;
    endtask

    initial begin
        test_reset();
        test_linear_ramp();
        test_negative_ramp();
        test_full_scale();
        test_underrun_resume();
        test_fifo_full();
        test_clear_mid_segment();
        test_reset_mid_segment();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
